// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the instruction-cycle sequencer: FSM states and phase codes.
// Used by cpu_cycle_sequencer with or without CPU_SEQ_WDT_EN.
package cpu_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   localparam logic [1:0] PHASE_FETCH  = 2'd0;
   localparam logic [1:0] PHASE_DECODE = 2'd1;
   localparam logic [1:0] PHASE_EXEC   = 2'd2;
   localparam logic [1:0] PHASE_WB     = 2'd3;

endpackage

// File: rtl/cpu_cycle_sequencer.sv
// Instruction-cycle controller: paces FETCH/DECODE/EXEC/WB on timing_generator steps.
// Define CPU_SEQ_WDT_EN to add the stalled-step watchdog (wdt_fault); otherwise it is tied 0.
//
// state  | meaning
// IDLE   | stopped, waiting for start; tg_en low
// FETCH  | mem_rd high; step loads IR and bumps PC
// DECODE | opcode valid; step latches it and picks HALT / FETCH (NOP) / EXEC
// EXEC   | alu_go per step; 1 step short op, EXEC_CYC steps long op
// WB     | step writes accumulator and closes the instruction boundary
// HALT   | stopped by HLT, halt request or watchdog; start resumes at FETCH
module cpu_cycle_sequencer
   import cpu_seq_pkg::*;
#(
   parameter int OPC_W     = 4,
   parameter int EXEC_CYC  = 2,
   parameter int CNT_W     = 8,
   parameter int WDT_LIMIT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             halt_req,
   input  logic             single_step,
   input  logic             step,
   input  logic [OPC_W-1:0] opcode,
   output logic             tg_en,
   output logic [1:0]       phase,
   output logic             mem_rd,
   output logic             ir_load,
   output logic             pc_inc,
   output logic             alu_go,
   output logic             acc_we,
   output logic             running,
   output logic             halted,
   output logic [CNT_W-1:0] instr_cnt,
   output logic             wdt_fault
);

   localparam logic [OPC_W-1:0] OPC_NOP = '0;
   localparam logic [OPC_W-1:0] OPC_HLT = '1;

   if (EXEC_CYC < 1 || EXEC_CYC > 15 || WDT_LIMIT < 1) begin : g_bad_param
      $error("cpu_cycle_sequencer: EXEC_CYC must be 1..15 and WDT_LIMIT >= 1");
   end

   state_t           state, state_nxt;
   logic             halt_pend;
   logic [3:0]       exec_cnt;
   logic [OPC_W-1:0] op_q;
   logic             retire;
   logic             exec_done;
   logic             halt_now;
   logic             wdt_trip;

`ifdef CPU_SEQ_WDT_EN
   localparam int WDT_W = $clog2(WDT_LIMIT + 1);
   logic [WDT_W-1:0] wdt_cnt;
   logic             wdt_fault_q;

   assign wdt_trip  = running && !step && (wdt_cnt == WDT_W'(WDT_LIMIT - 1));
   assign wdt_fault = wdt_fault_q;
`else
   assign wdt_trip  = 1'b0;
   assign wdt_fault = 1'b0;
`endif

   // A request arriving on the boundary clock itself is honoured immediately.
   assign halt_now  = halt_pend | halt_req;
   assign exec_done = op_q[OPC_W-1] ? (exec_cnt == 4'(EXEC_CYC - 1)) : 1'b1;

   assign running = (state == ST_FETCH) || (state == ST_DECODE) ||
                    (state == ST_EXEC)  || (state == ST_WB);
   assign halted  = (state == ST_HALT);
   assign tg_en   = running;
   assign mem_rd  = (state == ST_FETCH);
   assign ir_load = step && (state == ST_FETCH);
   assign pc_inc  = step && (state == ST_FETCH);
   assign alu_go  = step && (state == ST_EXEC);
   assign acc_we  = step && (state == ST_WB) && (op_q != OPC_NOP);

   always_comb begin
      phase = PHASE_FETCH;
      case (state)
         ST_DECODE: phase = PHASE_DECODE;
         ST_EXEC:   phase = PHASE_EXEC;
         ST_WB:     phase = PHASE_WB;
         default:   phase = PHASE_FETCH;
      endcase
   end

   always_comb begin
      state_nxt = state;
      retire    = 1'b0;
      case (state)
         ST_IDLE, ST_HALT: begin
            if (start) state_nxt = halt_req ? ST_HALT : ST_FETCH;
         end
         ST_FETCH: begin
            if (step) state_nxt = ST_DECODE;
         end
         ST_DECODE: begin
            if (step) begin
               if (opcode == OPC_HLT) begin
                  state_nxt = ST_HALT;
               end else if (opcode == OPC_NOP) begin
                  retire    = 1'b1;
                  state_nxt = halt_now ? ST_HALT : ST_FETCH;
               end else begin
                  state_nxt = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            if (step && exec_done) state_nxt = ST_WB;
         end
         ST_WB: begin
            if (step) begin
               retire = 1'b1;
               if (halt_now)         state_nxt = ST_HALT;
               else if (single_step) state_nxt = ST_IDLE;
               else                  state_nxt = ST_FETCH;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (wdt_trip) state_nxt = ST_HALT;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halt_pend <= 1'b0;
         exec_cnt  <= '0;
         op_q      <= '0;
         instr_cnt <= '0;
`ifdef CPU_SEQ_WDT_EN
         wdt_cnt     <= '0;
         wdt_fault_q <= 1'b0;
`endif
      end else begin
         if (state_nxt == ST_HALT) halt_pend <= 1'b0;
         else if (halt_req)        halt_pend <= 1'b1;

         if (state != ST_EXEC)  exec_cnt <= '0;
         else if (step)         exec_cnt <= exec_done ? 4'd0 : exec_cnt + 4'd1;

         if (state == ST_DECODE && step) op_q <= opcode;
         if (retire) instr_cnt <= instr_cnt + 1'b1;
`ifdef CPU_SEQ_WDT_EN
         if (!running || step) wdt_cnt <= '0;
         else                  wdt_cnt <= wdt_cnt + 1'b1;
         if (wdt_trip) wdt_fault_q <= 1'b1;
`endif
      end
   end

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Directed bench for cpu_cycle_sequencer with an inline timing_generator model (step every 4 clks).
// Watchdog scenario is exercised when CPU_SEQ_WDT_EN is defined.
module tb_cpu_cycle_sequencer;

   localparam int OPC_W     = 4;
   localparam int EXEC_CYC  = 2;
   localparam int CNT_W     = 8;
   localparam int WDT_LIMIT = 16;

   logic             clk;
   logic             rst_n;
   logic             start, halt_req, single_step;
   logic             step, step_gen, step_frc, stall;
   logic [OPC_W-1:0] opcode;
   logic             tg_en, mem_rd, ir_load, pc_inc, alu_go, acc_we;
   logic             running, halted, wdt_fault;
   logic [1:0]       phase;
   logic [CNT_W-1:0] instr_cnt;
   logic [1:0]       tg_cnt;

   int checks = 0;
   int errors = 0;

   cpu_cycle_sequencer #(
      .OPC_W(OPC_W), .EXEC_CYC(EXEC_CYC), .CNT_W(CNT_W), .WDT_LIMIT(WDT_LIMIT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
      .single_step(single_step), .step(step), .opcode(opcode),
      .tg_en(tg_en), .phase(phase), .mem_rd(mem_rd), .ir_load(ir_load),
      .pc_inc(pc_inc), .alu_go(alu_go), .acc_we(acc_we), .running(running),
      .halted(halted), .instr_cnt(instr_cnt), .wdt_fault(wdt_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // timing_generator model: while enabled, one step pulse every 4 clocks
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tg_cnt   <= 2'd0;
         step_gen <= 1'b0;
      end else if (!tg_en) begin
         tg_cnt   <= 2'd0;
         step_gen <= 1'b0;
      end else begin
         tg_cnt   <= tg_cnt + 2'd1;
         step_gen <= (tg_cnt == 2'd2) && !stall;
      end
   end
   assign step = step_gen | step_frc;

   int          cyc = 0, n_ir = 0, n_pc = 0, n_alu = 0, n_acc = 0, n_mem = 0;
   int          alu_prev = 0, alu_last = 0, acc_last = 0;
   logic [31:0] ph_hist = 32'd0;
   logic [1:0]  last_ph = 2'd0;

   always @(negedge clk) begin
      cyc++;
      if (ir_load) n_ir++;
      if (pc_inc)  n_pc++;
      if (mem_rd)  n_mem++;
      if (alu_go) begin
         n_alu++;
         alu_prev = alu_last;
         alu_last = cyc;
      end
      if (acc_we) begin
         n_acc++;
         acc_last = cyc;
      end
      if (phase !== last_ph) begin
         ph_hist = {ph_hist[29:0], phase};
         last_ph = phase;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic bit cond(input int sel, input int val);
      case (sel)
         0:       return int'(phase) == val;
         1:       return int'(halted) == val;
         2:       return int'(running) == val;
         default: return int'(instr_cnt) == val;
      endcase
   endfunction

   task automatic wait_until(input int sel, input int val, input string tag, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         tick();
         ok = cond(sel, val);
      end
      checks++;
      assert (ok === 1'b1) else begin
         errors++;
         $error("FAIL %s: condition not met within %0d clks, observed 0 expected 1", tag, budget);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   int b_ir, b_pc, b_alu, b_acc, b_mem, c_stall;

   task automatic snap();
      b_ir = n_ir; b_pc = n_pc; b_alu = n_alu; b_acc = n_acc; b_mem = n_mem;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; single_step = 1'b0;
      step_frc = 1'b0; stall = 1'b0; opcode = '0;
      tick(); tick();
      chk("reset_outputs", {tg_en, phase, mem_rd, ir_load, pc_inc, alu_go, acc_we,
                            running, halted, instr_cnt, wdt_fault}, 32'd0);
      rst_n = 1'b1;
      tick();

      step_frc = 1'b1; tick(); step_frc = 1'b0; tick();
      chk("idle_step_ignored", {running, halted, instr_cnt}, 32'd0);

      // short op, single-step
      opcode = 4'h3; single_step = 1'b1; snap();
      pulse_start();
      chk("start_running", {running, tg_en}, 32'd3);
      wait_until(2, 0, "op3_done", 100);
      chk("op3_ir_load", n_ir - b_ir, 1);
      chk("op3_pc_inc", n_pc - b_pc, 1);
      chk("op3_alu_go", n_alu - b_alu, 1);
      chk("op3_acc_we", n_acc - b_acc, 1);
      chk("op3_mem_rd_clks", n_mem - b_mem, 4);
      chk("op3_phase_seq", ph_hist[7:0], 32'h6C);
      chk("op3_instr_cnt", instr_cnt, 1);
      chk("op3_idle_tg_en", {tg_en, halted}, 32'd0);

      // long op
      opcode = 4'h9; snap();
      pulse_start();
      wait_until(2, 0, "op9_done", 100);
      chk("op9_alu_go", n_alu - b_alu, 2);
      chk("op9_alu_spacing", alu_last - alu_prev, 4);
      chk("op9_acc_after_alu", acc_last - alu_last, 4);
      chk("op9_acc_we", n_acc - b_acc, 1);
      chk("op9_instr_cnt", instr_cnt, 2);

      // NOP, free-running; then finish with a single-stepped op
      opcode = 4'h0; single_step = 1'b0; snap();
      pulse_start();
      wait_until(3, 3, "nop_retire", 100);
      chk("nop_no_alu_acc", {n_alu - b_alu, n_acc - b_acc}, 32'd0);
      chk("nop_ir_load", n_ir - b_ir, 1);
      chk("nop_back_to_fetch", {running, phase}, 32'd4);
      opcode = 4'h3; single_step = 1'b1;
      wait_until(2, 0, "after_nop_done", 100);
      chk("after_nop_cnt", instr_cnt, 4);

      // start and halt_req together in IDLE
      start = 1'b1; halt_req = 1'b1; tick(); start = 1'b0; halt_req = 1'b0;
      chk("halt_wins", {halted, running}, 32'd2);
      chk("halt_wins_cnt", instr_cnt, 4);

      // HLT opcode
      opcode = 4'hF; single_step = 1'b0;
      pulse_start();
      chk("resume_from_halt", {halted, running}, 32'd1);
      wait_until(1, 1, "hlt_halts", 100);
      chk("hlt_state", {halted, tg_en, running, phase}, 32'h10);
      chk("hlt_not_counted", instr_cnt, 4);

      // halt request during EXEC of a long op; start while running ignored
      opcode = 4'h9; snap();
      pulse_start();
      wait_until(0, 1, "reach_decode", 20);
      start = 1'b1; tick(); start = 1'b0;
      chk("start_ignored", {halted, phase}, 32'd1);
      wait_until(0, 2, "reach_exec", 20);
      halt_req = 1'b1; tick(); halt_req = 1'b0;
      wait_until(1, 1, "halt_at_boundary", 100);
      chk("halt_alu_go", n_alu - b_alu, 2);
      chk("halt_acc_we", n_acc - b_acc, 1);
      chk("halt_cnt", instr_cnt, 5);

      // counter wrap over NOPs, then halt on a NOP boundary
      opcode = 4'h0;
      pulse_start();
      wait_until(3, 0, "cnt_wrap", 3000);
      chk("wrap_running", {running, halted}, 32'd2);
      halt_req = 1'b1; tick(); halt_req = 1'b0;
      wait_until(1, 1, "nop_halt", 50);
      chk("nop_halt_cnt", instr_cnt, 1);

      // asynchronous reset mid-EXEC
      opcode = 4'h9;
      pulse_start();
      wait_until(0, 2, "reset_reach_exec", 50);
      #2 rst_n = 1'b0;
      #1;
      chk("reset_mid_exec", {tg_en, phase, mem_rd, ir_load, pc_inc, alu_go, acc_we,
                             running, halted, instr_cnt, wdt_fault}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

`ifdef CPU_SEQ_WDT_EN
      opcode = 4'h3; single_step = 1'b0;
      pulse_start();
      wait_until(0, 1, "wdt_reach_decode", 20);
      stall = 1'b1; c_stall = cyc;
      wait_until(1, 1, "wdt_halts", 40);
      chk("wdt_latency", cyc - c_stall, WDT_LIMIT);
      chk("wdt_fault_set", {wdt_fault, tg_en}, 32'd2);
      stall = 1'b0; single_step = 1'b1;
      pulse_start();
      wait_until(2, 0, "wdt_resume_done", 100);
      chk("wdt_sticky_idle", {wdt_fault, halted, instr_cnt}, 32'h200 | 32'd1);
`else
      opcode = 4'h3; single_step = 1'b1;
      pulse_start();
      wait_until(0, 1, "stall_reach_decode", 20);
      stall = 1'b1;
      repeat (40) tick();
      chk("stall_waits", {halted, wdt_fault, phase}, 32'd1);
      stall = 1'b0;
      wait_until(2, 0, "stall_resume_done", 100);
      chk("stall_done_cnt", {halted, instr_cnt}, 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
